trig_taylor_accel: RTL and testbench
====================================

# trig_taylor_accel

Parametrised iterative fixed-point sine/cosine accelerator. It evaluates a truncated Taylor series of configurable length and data width, with runtime selection between cos(x) and sin(x). The block is the drop-in successor to the fixed 10-bit cosine accelerator: it keeps the same start/ready handshake and adds a busy flag, a mode input, and output saturation.

## Interface
- W, 10, data width; x and result are unsigned Q0.W fractions (value = code/2^W); legal range 4..16
- TERMS, 4, number of series terms evaluated; legal range 1..6
- clk  input  1  rising-edge clock
- rst  input  1  reset, synchronous, active-low
- start  input  1  request; sampled only in IDLE
- mode  input  1  0 = cos(x), 1 = sin(x); captured with start
- x  input  W  operand, Q0.W; captured with start
- result  output  W  Q0.W result; held until the next completion
- ready  output  1  result valid; level signal
- busy  output  1  high whenever state != IDLE

## Operation
- States: IDLE, SQR, CALC, DONE.
- IDLE, with start=1 at an edge:
  - capture x_r <= x and mode_r <= mode
  - ready <= 0
  - go to SQR
- SQR:
  - x2 <= (x_r*x_r) >> W
  - term <= mode_r ? x_r : 2^W
  - acc <= 0, k <= 0
  - go to CALC
- CALC, one term per cycle:
  - p = (term*coef[k]) >> W
  - acc <= acc + p if k is even, acc - p if k is odd
  - term <= (term*x2) >> W
  - k <= k+1
  - after TERMS cycles (k = TERMS-1 processed), go to DONE
- DONE:
  - result <= sat(acc), ready <= 1
  - go to IDLE
- Coefficients are elaboration-time constants, W+1 bits unsigned:
  - cos: coef[k] = floor(2^W / (2k)!)
  - sin: coef[k] = floor(2^W / (2k+1)!)
- Widths:
  - term: W+1 unsigned
  - x2: W unsigned
  - products: full 2W+2 bits, then floor shift by W
  - acc: W+3 signed
- Saturation: acc < 0 -> 0; acc >= 2^W -> 2^W-1; otherwise acc[W-1:0].
- start, mode and x are ignored outside IDLE; operands may change freely while busy.

## Timing
- Reset (rst=0 at an edge, any state, including mid-computation):
  - state <= IDLE
  - result <= 0, ready <= 0, busy <= 0
  - acc, term, k <= 0
  - no pending request survives reset
- Latency:
  - acceptance edge E moves the block to SQR
  - result and ready update at edge E+TERMS+2 (E+6 for TERMS=4)
- busy:
  - combinational from state
  - high from edge E through edge E+TERMS+2
  - low in the cycle ready rises
- ready:
  - rises at the DONE edge
  - stays high in IDLE until the next acceptance edge, which clears it
- start held high continuously: the block re-accepts on the first IDLE edge after DONE, so ready is high for exactly one cycle between back-to-back operations.
- start asserted while busy has no effect and is not queued.
- result changes only at DONE edges and on reset.

## Test plan
- W=10, TERMS=4, mode=0, x=0, start pulsed one cycle -> busy for 6 cycles, then ready=1, result=1023 (saturated from acc=1024).
- mode=0, x=512 (0.5) -> result=898; mode=1, x=512 -> result=491.
- mode=0, x=1023 -> result=554; mode=1, x=0 -> result=0.
- Hold start=1 across two operations with x changed to 512 mid-computation:
  - first result corresponds to the originally captured x
  - ready high for exactly 1 cycle between the two operations
  - mid-computation change of x has no effect
- Drive rst=0 at the second CALC cycle -> next cycle has ready=0, result=0, busy=0; a new start then completes normally with the correct value.
- Sweep all 1024 x values in both modes and compare against a floating-point model:
  - |error| <= 2 LSB for TERMS=4
  - rerun with W=12, TERMS=5, |error| <= 3 LSB

Source files
------------

// File: rtl/trig_taylor_accel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | trig_taylor_accel                                                          |
// | Iterative fixed-point cos/sin evaluator using a truncated Taylor series.   |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module trig_taylor_accel #(
  parameter int W     = 10,
  parameter int TERMS = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_start,
  input  logic         i_mode,
  input  logic [W-1:0] i_x,
  output logic [W-1:0] o_result,
  output logic         o_ready,
  output logic         o_busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SQR  = 2'd1,
    S_CALC = 2'd2,
    S_DONE = 2'd3
  } state_t;

  // floor(2^W / n!) with n = 2k (cos) or 2k+1 (sin)
  function automatic logic [W:0] coef_f(input logic is_sin, input int k);
    logic [63:0] f;
    logic [63:0] q;
    int          n;
    f = 64'd1;
    n = 2 * k + (is_sin ? 1 : 0);
    for (int i = 2; i <= n; i++) f = f * 64'(i);
    q = (64'd1 << W) / f;
    return (W+1)'(q);
  endfunction

  localparam logic [W:0] c_cos_coef [0:7] = '{
    coef_f(1'b0, 0), coef_f(1'b0, 1), coef_f(1'b0, 2), coef_f(1'b0, 3),
    coef_f(1'b0, 4), coef_f(1'b0, 5), coef_f(1'b0, 6), coef_f(1'b0, 7)
  };
  localparam logic [W:0] c_sin_coef [0:7] = '{
    coef_f(1'b1, 0), coef_f(1'b1, 1), coef_f(1'b1, 2), coef_f(1'b1, 3),
    coef_f(1'b1, 4), coef_f(1'b1, 5), coef_f(1'b1, 6), coef_f(1'b1, 7)
  };
  localparam logic [W:0] c_one    = {1'b1, {W{1'b0}}};
  localparam logic [2:0] c_last_k = 3'(TERMS - 1);

  state_t         r_state;
  state_t         w_state_nxt;
  logic [W-1:0]   r_x;
  logic           r_mode;
  logic [W-1:0]   r_x2;
  logic [W:0]     r_term;
  logic [W+2:0]   r_acc;
  logic [2:0]     r_k;
  logic [W-1:0]   r_result;
  logic           r_ready;

  logic [2*W-1:0] w_sq;
  logic [W-1:0]   w_x2_nxt;
  logic [W:0]     w_coef;
  logic [2*W+1:0] w_prod_c;
  logic [2*W+1:0] w_prod_t;
  logic [W+2:0]   w_p;
  logic [W:0]     w_term_nxt;
  logic [W-1:0]   w_sat;

  assign w_sq       = {{W{1'b0}}, r_x} * {{W{1'b0}}, r_x};
  assign w_x2_nxt   = W'(w_sq >> W);
  assign w_coef     = r_mode ? c_sin_coef[r_k] : c_cos_coef[r_k];
  assign w_prod_c   = {{(W+1){1'b0}}, r_term} * {{(W+1){1'b0}}, w_coef};
  assign w_prod_t   = {{(W+1){1'b0}}, r_term} * {{(W+2){1'b0}}, r_x2};
  assign w_p        = (W+3)'(w_prod_c >> W);
  assign w_term_nxt = (W+1)'(w_prod_t >> W);

  // Accumulator is two's complement; clamp to the representable [0, 2^W-1]
  always_comb begin
    w_sat = r_acc[W-1:0];
    if (r_acc[W+2])
      w_sat = '0;
    else if (|r_acc[W+1:W])
      w_sat = '1;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (i_start) w_state_nxt = S_SQR;
      S_SQR:   w_state_nxt = S_CALC;
      S_CALC:  if (r_k == c_last_k) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst)
      r_state <= S_IDLE;
    else
      r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_x      <= '0;
      r_mode   <= 1'b0;
      r_x2     <= '0;
      r_term   <= '0;
      r_acc    <= '0;
      r_k      <= '0;
      r_result <= '0;
      r_ready  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_x     <= i_x;
            r_mode  <= i_mode;
            r_ready <= 1'b0;
          end
        end
        S_SQR: begin
          r_x2   <= w_x2_nxt;
          r_term <= r_mode ? {1'b0, r_x} : c_one;
          r_acc  <= '0;
          r_k    <= '0;
        end
        S_CALC: begin
          r_acc  <= r_k[0] ? (r_acc - w_p) : (r_acc + w_p);
          r_term <= w_term_nxt;
          r_k    <= r_k + 3'd1;
        end
        S_DONE: begin
          r_result <= w_sat;
          r_ready  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign o_result = r_result;
  assign o_ready  = r_ready;
  assign o_busy   = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_trig_taylor_accel.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_trig_taylor_accel                                                       |
// | Self-checking bench: vector table, corner sequences, sweeps vs models.     |
// | Rev 1.0 - initial release                                                  |
// +----------------------------------------------------------------------------+
module tb_trig_taylor_accel;

  logic        clk = 1'b0;
  logic        rst;
  logic        s1, m1, s2, m2;
  logic [9:0]  x1;
  logic [11:0] x2;
  logic [9:0]  res1;
  logic [11:0] res2;
  logic        rdy1, bsy1, rdy2, bsy2;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  trig_taylor_accel #(.W(10), .TERMS(4)) dut (
    .clk(clk), .rst(rst), .i_start(s1), .i_mode(m1), .i_x(x1),
    .o_result(res1), .o_ready(rdy1), .o_busy(bsy1)
  );

  trig_taylor_accel #(.W(12), .TERMS(5)) dut2 (
    .clk(clk), .rst(rst), .i_start(s2), .i_mode(m2), .i_x(x2),
    .o_result(res2), .o_ready(rdy2), .o_busy(bsy2)
  );

  typedef struct {
    bit mode;
    int x;
    int exp_res;
  } vec_t;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_tol(input string name, input int w, input bit m, input int xv,
                         input int act, input real tol);
    real scale, ref_v, e;
    scale = real'(1 << w);
    ref_v = (m ? $sin(real'(xv) / scale) : $cos(real'(xv) / scale)) * scale;
    e = real'(act) - ref_v;
    if (e < 0.0) e = -e;
    n_checks++;
    if (e > tol) begin
      n_err++;
      $display("FAIL %s: mode=%0d x=%0d got %0d, float ref %f (tol %f)",
               name, m, xv, act, ref_v, tol);
    end
  endtask

  // Series evaluated straight from the arithmetic rules with 64-bit integers
  function automatic int model(input int w, input int terms, input bit m, input int xv);
    longint one, xs, term, acc, fact, coef, p;
    one  = longint'(1) << w;
    xs   = (longint'(xv) * longint'(xv)) >> w;
    term = m ? longint'(xv) : one;
    acc  = 0;
    for (int k = 0; k < terms; k++) begin
      fact = 1;
      for (int i = 2; i <= 2 * k + int'(m); i++) fact = fact * i;
      coef = one / fact;
      p    = (term * coef) >> w;
      acc  = (k % 2 == 1) ? acc - p : acc + p;
      term = (term * xs) >> w;
    end
    if (acc < 0) return 0;
    if (acc >= one) return int'(one - 1);
    return int'(acc);
  endfunction

  // One start pulse; reports result, busy-cycle count, busy at completion
  task automatic do_op(input bit sel, input bit m, input int xv,
                       output int res, output int busy_cnt, output bit busy_at_rdy);
    bit ok;
    @(negedge clk);
    if (sel) begin s2 = 1'b1; m2 = m; x2 = xv[11:0]; end
    else     begin s1 = 1'b1; m1 = m; x1 = xv[9:0];  end
    @(negedge clk);
    s1 = 1'b0; s2 = 1'b0;
    x1 = 10'($urandom); x2 = 12'($urandom);
    m1 = 1'($urandom);  m2 = 1'($urandom);
    busy_cnt = 0; ok = 1'b0; busy_at_rdy = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (sel ? rdy2 : rdy1) begin ok = 1'b1; break; end
      if (sel ? bsy2 : bsy1) busy_cnt++;
      @(negedge clk);
    end
    busy_at_rdy = sel ? bsy2 : bsy1;
    if (!ok) chk("op timeout", 0, 1);
    res = sel ? int'(res2) : int'(res1);
  endtask

  task automatic wait_ready1(output bit ok);
    ok = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (rdy1) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    if (!ok) chk("wait ready timeout", 0, 1);
  endtask

  initial begin
    vec_t vecs[$];
    int   res, bc, xv;
    bit   bar, ok, m;

    vecs.push_back('{1'b0, 0,    1023});
    vecs.push_back('{1'b0, 512,  898});
    vecs.push_back('{1'b1, 512,  491});
    vecs.push_back('{1'b0, 1023, 554});
    vecs.push_back('{1'b1, 0,    0});
    vecs.push_back('{1'b1, 1023, 861});

    rst = 1'b0; s1 = 1'b0; m1 = 1'b0; x1 = '0; s2 = 1'b0; m2 = 1'b0; x2 = '0;
    repeat (3) @(negedge clk);
    chk("reset result", int'(res1), 0);
    chk("reset ready", int'(rdy1), 0);
    chk("reset busy", int'(bsy1), 0);
    rst = 1'b1;

    foreach (vecs[i]) begin
      do_op(1'b0, vecs[i].mode, vecs[i].x, res, bc, bar);
      chk($sformatf("vec%0d result", i), res, vecs[i].exp_res);
      chk($sformatf("vec%0d busy cycles", i), bc, 6);
      chk($sformatf("vec%0d busy at ready", i), int'(bar), 0);
    end

    // Start held high across two operations; x changes mid-computation
    @(negedge clk);
    s1 = 1'b1; m1 = 1'b0; x1 = 10'd0;
    @(negedge clk);
    x1 = 10'd512;
    wait_ready1(ok);
    chk("b2b first result", int'(res1), 1023);
    @(negedge clk);
    chk("b2b ready one cycle", int'(rdy1), 0);
    chk("b2b reaccepted busy", int'(bsy1), 1);
    wait_ready1(ok);
    chk("b2b second result", int'(res1), 898);
    @(negedge clk);
    chk("b2b second ready one cycle", int'(rdy1), 0);
    s1 = 1'b0;
    wait_ready1(ok);
    chk("b2b third result", int'(res1), 898);

    // Reset during the second CALC cycle
    @(negedge clk);
    s1 = 1'b1; m1 = 1'b0; x1 = 10'd512;
    @(negedge clk);
    s1 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("midreset ready", int'(rdy1), 0);
    chk("midreset result", int'(res1), 0);
    chk("midreset busy", int'(bsy1), 0);
    rst = 1'b1;
    @(negedge clk);
    chk("post reset idle busy", int'(bsy1), 0);
    do_op(1'b0, 1'b1, 1023, res, bc, bar);
    chk("post reset result", res, 861);
    chk("post reset busy cycles", bc, 6);

    // Full sweep, W=10 TERMS=4
    for (int xi = 0; xi < 1024; xi++) begin
      for (int mi = 0; mi < 2; mi++) begin
        do_op(1'b0, 1'(mi), xi, res, bc, bar);
        chk($sformatf("sweep m=%0d x=%0d", mi, xi), res, model(10, 4, 1'(mi), xi));
        chk_tol("sweep float", 10, 1'(mi), xi, res, 2.0);
      end
    end

    // Randomized, W=12 TERMS=5
    for (int n = 0; n < 300; n++) begin
      xv = (n < 2) ? (n * 4095) : int'($urandom_range(0, 4095));
      m  = 1'($urandom);
      do_op(1'b1, m, xv, res, bc, bar);
      chk($sformatf("w12 m=%0d x=%0d", m, xv), res, model(12, 5, m, xv));
      chk_tol("w12 float", 12, m, xv, res, 3.0);
      if (n == 0) chk("w12 busy cycles", bc, 7);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
